trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- M-mode trap sequencer that sits directly upstream of the CSR file.
- Accepts synchronous exceptions and MRET from commit, and arbitrates pending interrupts from mip/mie.
- Owns the trap-state CSRs (mepc, mcause, mtval, mstatus MIE/MPIE/MPP, current privilege).
- Issues a single redirect PC to the frontend through a valid/ready handshake, including a one-shot boot redirect after reset.

Parameters:
- MXLEN, 64, register width.
- BOOT_PC, 64'h400, first fetch PC after reset ({62'h100, 2'b00}).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- exception_valid_i  in  1  synchronous exception at commit.
- exception_code_i  in  63  synchronous exception code.
- exception_pc_i  in  64  PC of the faulting instruction.
- exception_tval_i  in  64  trap value.
- mret_valid_i  in  1  MRET committing.
- commit_pc_i  in  64  next-to-commit PC; becomes mepc on an interrupt.
- mip_i  in  64  pending interrupts.
- mie_i  in  64  interrupt enables.
- mtvec_i  in  64  {base[61:0], mode[1:0]}.
- csr_we_i  in  1  software CSR write strobe.
- csr_addr_i  in  12  CSR address (0x300 mstatus, 0x341 mepc, 0x342 mcause, 0x343 mtval).
- csr_wdata_i  in  64  CSR write data.
- redirect_valid_o  out  1  redirect request.
- redirect_pc_o  out  64  redirect target.
- redirect_ready_i  in  1  frontend accepts the redirect.
- busy_o  out  1  high while not IDLE; upstream stalls commit.
- mepc_o  out  64
- mcause_o  out  64  {interrupt, code}.
- mtval_o  out  64
- mstatus_mie_o  out  1
- mstatus_mpie_o  out  1
- mstatus_mpp_o  out  2
- privilege_o  out  2  00 U, 01 S, 11 M.

Behaviour:
- Reset (asynchronous):
  - State BOOT.
  - redirect_valid_o=1, redirect_pc_o=BOOT_PC.
  - mepc_o=0, mcause_o=0, mtval_o=0.
  - mie=0, mpie=0, mpp=2'b11, privilege=2'b11.
  - busy_o=1.
- States BOOT, IDLE, REDIRECT:
  - BOOT -> IDLE on redirect_ready_i.
  - REDIRECT -> IDLE on redirect_ready_i.
  - redirect_valid_o is held and redirect_pc_o is stable until accepted.
- In BOOT and REDIRECT, all event inputs and CSR writes are ignored; upstream must honour busy_o.
- In IDLE, events are evaluated each cycle with priority exception > interrupt > mret. Only one event is taken; the losers are dropped (commit re-presents them).
- Interrupt eligibility: (privilege != M) or mie=1, with at least one bit set in mip_i & mie_i among bits {11,3,7,9,1,5,13}.
- Interrupt priority: MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5) > LCOFI(13).
- Trap, applied at the clock edge of cycle N; results visible at N+1:
  - mepc = pc & ~64'h1. pc is exception_pc_i for an exception, commit_pc_i for an interrupt.
  - mcause = {is_irq, code}.
  - mtval = exception_tval_i for an exception, 0 for an interrupt.
  - mpie = mie; mie = 0; mpp = privilege; privilege = M.
- Trap target:
  - mode=01 with an interrupt: {base,2'b00} + 4*code.
  - Otherwise (including modes 10 and 11): {base,2'b00}.
  - Addition wraps modulo 2^64.
- MRET:
  - mie = mpie; mpie = 1; privilege = mpp; mpp = 2'b00.
  - Target = mepc as it was before this cycle.
- Any taken event moves IDLE -> REDIRECT, with redirect_valid_o=1 at N+1 (latency 1).
- CSR writes, IDLE only:
  - mepc write clears bit0.
  - mstatus write updates only bits 3, 7, 12:11. An MPP value of 10 is written as 00.
  - If a trap or MRET is taken in the same cycle, the event wins and the CSR write is discarded.
- Reset mid-REDIRECT returns to BOOT; the pending redirect is lost.

Test Plan:
- Reset release, ready=0 for 3 cycles then 1 -> redirect_valid_o=1 with pc 0x400 held all 4 cycles; then IDLE, busy_o=0.
- Illegal instruction: exception_code=2, pc=0x8000_0102, tval=0xDEAD, mtvec=0x8000_0000 -> next cycle mepc=0x8000_0102, mcause=2, mtval=0xDEAD, mie=0, mpie=old mie, redirect_pc=0x8000_0000.
- Vectored MTI: mtvec=0x8000_0001, mie=1, mip=mie_i=0x80, commit_pc=0x1234 -> mcause=0x8000_0000_0000_0007, mepc=0x1234, mtval=0, redirect_pc=0x8000_001C.
- Priority: exception (code 5) plus MEI pending in the same cycle -> mcause=5; with mie=0 in M-mode and MEI pending, no trap is taken.
- MRET with mepc=0x2000, mpie=1, mpp=00 -> privilege=00, mie=1, mpie=1, mpp=00, redirect_pc=0x2000.
- CSR write to mepc of 0x3001 in IDLE -> mepc_o=0x3000; the same write coincident with an exception is discarded and the trap values are stored.

Source files
------------

// File: rtl/trap_controller.sv
// trap_controller: M-mode trap sequencer sitting directly upstream of the CSR file.
//
// Takes synchronous exceptions and MRET from commit and arbitrates pending interrupts
// (mip & mie). It owns the trap-state CSRs (mepc, mcause, mtval, mstatus MIE/MPIE/MPP and
// the current privilege). It issues one redirect PC at a time to the frontend over a
// valid/ready handshake. After reset it issues a single boot redirect to BOOT_PC.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   exception_valid_i/code_i/pc_i/tval_i
//                                 synchronous exception presented at commit
//   mret_valid_i                  MRET committing
//   commit_pc_i                   next-to-commit PC; saved to mepc on an interrupt
//   mip_i, mie_i                  pending / enabled interrupt vectors
//   mtvec_i                       {base, mode}; mode 01 vectors interrupts
//   csr_we_i/addr_i/wdata_i       software writes to mstatus/mepc/mcause/mtval
//   redirect_valid_o/pc_o, redirect_ready_i
//                                 redirect handshake toward the frontend
//   busy_o                        high outside IDLE; commit must stall
//   mepc_o, mcause_o, mtval_o, mstatus_mie_o, mstatus_mpie_o, mstatus_mpp_o, privilege_o
//                                 trap-state CSR values
module trap_controller #(
  parameter int unsigned      MXLEN   = 64,
  parameter logic [MXLEN-1:0] BOOT_PC = MXLEN'(64'h400)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             exception_valid_i,
  input  logic [MXLEN-2:0] exception_code_i,
  input  logic [MXLEN-1:0] exception_pc_i,
  input  logic [MXLEN-1:0] exception_tval_i,
  input  logic             mret_valid_i,
  input  logic [MXLEN-1:0] commit_pc_i,
  input  logic [MXLEN-1:0] mip_i,
  input  logic [MXLEN-1:0] mie_i,
  input  logic [MXLEN-1:0] mtvec_i,
  input  logic             csr_we_i,
  input  logic [11:0]      csr_addr_i,
  input  logic [MXLEN-1:0] csr_wdata_i,
  output logic             redirect_valid_o,
  output logic [MXLEN-1:0] redirect_pc_o,
  input  logic             redirect_ready_i,
  output logic             busy_o,
  output logic [MXLEN-1:0] mepc_o,
  output logic [MXLEN-1:0] mcause_o,
  output logic [MXLEN-1:0] mtval_o,
  output logic             mstatus_mie_o,
  output logic             mstatus_mpie_o,
  output logic [1:0]       mstatus_mpp_o,
  output logic [1:0]       privilege_o
);

  localparam logic [1:0]  PrivM      = 2'b11;
  localparam logic [1:0]  PrivU      = 2'b00;
  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtval   = 12'h343;

  // Interrupt lines this block arbitrates: bits 1, 3, 5, 7, 9, 11, 13.
  localparam logic [MXLEN-1:0] IrqMask = MXLEN'(64'h2AAA);

  typedef enum logic [1:0] {
    StBoot,
    StIdle,
    StRedirect
  } state_e;

  state_e           state_q;
  logic             redirect_valid_q;
  logic [MXLEN-1:0] redirect_pc_q;
  logic [MXLEN-1:0] mepc_q;
  logic [MXLEN-1:0] mcause_q;
  logic [MXLEN-1:0] mtval_q;
  logic             mie_q;
  logic             mpie_q;
  logic [1:0]       mpp_q;
  logic [1:0]       priv_q;

  // Event decode for the current cycle.
  logic [MXLEN-1:0] irq_pend;
  logic [5:0]       irq_code;
  logic             irq_take;
  logic             trap_take;
  logic [MXLEN-1:0] trap_base;
  logic [MXLEN-1:0] trap_pc;
  logic [MXLEN-1:0] trap_cause;
  logic [MXLEN-1:0] trap_tval;
  logic [MXLEN-1:0] trap_target;
  logic [1:0]       mpp_wdata;

  always_comb begin
    irq_pend = mip_i & mie_i & IrqMask;

    // Fixed priority MEI > MSI > MTI > SEI > SSI > STI > LCOFI.
    irq_code = 6'd13;
    if (irq_pend[11]) begin
      irq_code = 6'd11;
    end else if (irq_pend[3]) begin
      irq_code = 6'd3;
    end else if (irq_pend[7]) begin
      irq_code = 6'd7;
    end else if (irq_pend[9]) begin
      irq_code = 6'd9;
    end else if (irq_pend[1]) begin
      irq_code = 6'd1;
    end else if (irq_pend[5]) begin
      irq_code = 6'd5;
    end

    // Below M-mode interrupts are always globally enabled.
    irq_take  = (|irq_pend) && ((priv_q != PrivM) || mie_q);
    trap_take = exception_valid_i || irq_take;
    trap_base = {mtvec_i[MXLEN-1:2], 2'b00};

    if (exception_valid_i) begin
      trap_pc     = exception_pc_i;
      trap_cause  = {1'b0, exception_code_i};
      trap_tval   = exception_tval_i;
      trap_target = trap_base;
    end else begin
      trap_pc    = commit_pc_i;
      trap_cause = {1'b1, {(MXLEN-7){1'b0}}, irq_code};
      trap_tval  = '0;
      // Only mode 01 vectors; the reserved modes behave as direct.
      if (mtvec_i[1:0] == 2'b01) begin
        trap_target = trap_base + {{(MXLEN-8){1'b0}}, irq_code, 2'b00};
      end else begin
        trap_target = trap_base;
      end
    end

    // MPP=10 (H) does not exist here; it is stored as U.
    mpp_wdata = (csr_wdata_i[12:11] == 2'b10) ? PrivU : csr_wdata_i[12:11];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= StBoot;
      redirect_valid_q <= 1'b1;
      redirect_pc_q    <= BOOT_PC;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mtval_q          <= '0;
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mpp_q            <= PrivM;
      priv_q           <= PrivM;
    end else begin
      unique case (state_q)
        StBoot, StRedirect: begin
          // Redirect is held unchanged until the frontend takes it; inputs are ignored.
          if (redirect_ready_i) begin
            state_q          <= StIdle;
            redirect_valid_q <= 1'b0;
          end
        end
        StIdle: begin
          if (trap_take) begin
            state_q          <= StRedirect;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= trap_target;
            mepc_q           <= {trap_pc[MXLEN-1:1], 1'b0};
            mcause_q         <= trap_cause;
            mtval_q          <= trap_tval;
            mpie_q           <= mie_q;
            mie_q            <= 1'b0;
            mpp_q            <= priv_q;
            priv_q           <= PrivM;
          end else if (mret_valid_i) begin
            state_q          <= StRedirect;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= mepc_q;
            mie_q            <= mpie_q;
            mpie_q           <= 1'b1;
            priv_q           <= mpp_q;
            mpp_q            <= PrivU;
          end else if (csr_we_i) begin
            // Software writes only land when no event is taken this cycle.
            unique case (csr_addr_i)
              CsrMstatus: begin
                mie_q  <= csr_wdata_i[3];
                mpie_q <= csr_wdata_i[7];
                mpp_q  <= mpp_wdata;
              end
              CsrMepc:   mepc_q   <= {csr_wdata_i[MXLEN-1:1], 1'b0};
              CsrMcause: mcause_q <= csr_wdata_i;
              CsrMtval:  mtval_q  <= csr_wdata_i;
              default: ;
            endcase
          end
        end
        default: begin
          state_q          <= StBoot;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= BOOT_PC;
        end
      endcase
    end
  end

  assign busy_o           = (state_q != StIdle);
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign mepc_o           = mepc_q;
  assign mcause_o         = mcause_q;
  assign mtval_o          = mtval_q;
  assign mstatus_mie_o    = mie_q;
  assign mstatus_mpie_o   = mpie_q;
  assign mstatus_mpp_o    = mpp_q;
  assign privilege_o      = priv_q;

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed bench for trap_controller.
// Inputs are driven 1 time unit after each rising edge and outputs are checked at that same
// point, so every check observes the state produced by the preceding edge.
module tb_trap_controller;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        exception_valid_i;
  logic [62:0] exception_code_i;
  logic [63:0] exception_pc_i;
  logic [63:0] exception_tval_i;
  logic        mret_valid_i;
  logic [63:0] commit_pc_i;
  logic [63:0] mip_i;
  logic [63:0] mie_i;
  logic [63:0] mtvec_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [63:0] csr_wdata_i;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;
  logic        redirect_ready_i;
  logic        busy_o;
  logic [63:0] mepc_o;
  logic [63:0] mcause_o;
  logic [63:0] mtval_o;
  logic        mstatus_mie_o;
  logic        mstatus_mpie_o;
  logic [1:0]  mstatus_mpp_o;
  logic [1:0]  privilege_o;

  int checks = 0;
  int errors = 0;

  trap_controller dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .exception_valid_i(exception_valid_i),
    .exception_code_i (exception_code_i),
    .exception_pc_i   (exception_pc_i),
    .exception_tval_i (exception_tval_i),
    .mret_valid_i     (mret_valid_i),
    .commit_pc_i      (commit_pc_i),
    .mip_i            (mip_i),
    .mie_i            (mie_i),
    .mtvec_i          (mtvec_i),
    .csr_we_i         (csr_we_i),
    .csr_addr_i       (csr_addr_i),
    .csr_wdata_i      (csr_wdata_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .redirect_ready_i (redirect_ready_i),
    .busy_o           (busy_o),
    .mepc_o           (mepc_o),
    .mcause_o         (mcause_o),
    .mtval_o          (mtval_o),
    .mstatus_mie_o    (mstatus_mie_o),
    .mstatus_mpie_o   (mstatus_mpie_o),
    .mstatus_mpp_o    (mstatus_mpp_o),
    .privilege_o      (privilege_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_events();
    exception_valid_i = 1'b0;
    mret_valid_i      = 1'b0;
    mip_i             = '0;
    mie_i             = '0;
    csr_we_i          = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [63:0] data);
    csr_we_i    = 1'b1;
    csr_addr_i  = addr;
    csr_wdata_i = data;
    step();
    csr_we_i = 1'b0;
  endtask

  // Accept the pending redirect and confirm the return to IDLE.
  task automatic accept(input string tag);
    redirect_ready_i = 1'b1;
    step();
    redirect_ready_i = 1'b0;
    chk({tag, "_busy_after_accept"}, 64'(busy_o), 64'd0);
    chk({tag, "_valid_after_accept"}, 64'(redirect_valid_o), 64'd0);
  endtask

  initial begin
    rst_i             = 1'b1;
    exception_valid_i = 1'b0;
    exception_code_i  = '0;
    exception_pc_i    = '0;
    exception_tval_i  = '0;
    mret_valid_i      = 1'b0;
    commit_pc_i       = '0;
    mip_i             = '0;
    mie_i             = '0;
    mtvec_i           = '0;
    csr_we_i          = 1'b0;
    csr_addr_i        = '0;
    csr_wdata_i       = '0;
    redirect_ready_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Reset state.
    chk("rst_valid", 64'(redirect_valid_o), 64'd1);
    chk("rst_pc", redirect_pc_o, 64'h400);
    chk("rst_busy", 64'(busy_o), 64'd1);
    chk("rst_mepc", mepc_o, 64'd0);
    chk("rst_mcause", mcause_o, 64'd0);
    chk("rst_mtval", mtval_o, 64'd0);
    chk("rst_mie", 64'(mstatus_mie_o), 64'd0);
    chk("rst_mpie", 64'(mstatus_mpie_o), 64'd0);
    chk("rst_mpp", 64'(mstatus_mpp_o), 64'd3);
    chk("rst_priv", 64'(privilege_o), 64'd3);

    // Boot redirect held while ready is low for three cycles.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("boot_hold_valid", 64'(redirect_valid_o), 64'd1);
      chk("boot_hold_pc", redirect_pc_o, 64'h400);
    end
    accept("boot");

    // Illegal instruction, direct mtvec.
    mtvec_i           = 64'h8000_0000;
    exception_valid_i = 1'b1;
    exception_code_i  = 63'd2;
    exception_pc_i    = 64'h8000_0102;
    exception_tval_i  = 64'hDEAD;
    step();
    clear_events();
    chk("ill_valid", 64'(redirect_valid_o), 64'd1);
    chk("ill_busy", 64'(busy_o), 64'd1);
    chk("ill_pc", redirect_pc_o, 64'h8000_0000);
    chk("ill_mepc", mepc_o, 64'h8000_0102);
    chk("ill_mcause", mcause_o, 64'd2);
    chk("ill_mtval", mtval_o, 64'hDEAD);
    chk("ill_mie", 64'(mstatus_mie_o), 64'd0);
    chk("ill_mpie", 64'(mstatus_mpie_o), 64'd0);
    chk("ill_mpp", 64'(mstatus_mpp_o), 64'd3);
    // Events during REDIRECT are ignored.
    mret_valid_i = 1'b1;
    step();
    mret_valid_i = 1'b0;
    chk("redir_ignore_pc", redirect_pc_o, 64'h8000_0000);
    chk("redir_ignore_priv", 64'(privilege_o), 64'd3);
    accept("ill");

    // mstatus write: MIE=1, MPIE=1, MPP=10 stored as 00.
    csr_write(12'h300, 64'h1088);
    chk("mst_mie", 64'(mstatus_mie_o), 64'd1);
    chk("mst_mpie", 64'(mstatus_mpie_o), 64'd1);
    chk("mst_mpp", 64'(mstatus_mpp_o), 64'd0);
    chk("mst_busy", 64'(busy_o), 64'd0);

    // Vectored MTI from M-mode with MIE=1.
    mtvec_i     = 64'h8000_0001;
    mip_i       = 64'h80;
    mie_i       = 64'h80;
    commit_pc_i = 64'h1234;
    step();
    clear_events();
    chk("mti_mcause", mcause_o, 64'h8000_0000_0000_0007);
    chk("mti_mepc", mepc_o, 64'h1234);
    chk("mti_mtval", mtval_o, 64'd0);
    chk("mti_pc", redirect_pc_o, 64'h8000_001C);
    chk("mti_mie", 64'(mstatus_mie_o), 64'd0);
    chk("mti_mpie", 64'(mstatus_mpie_o), 64'd1);
    chk("mti_mpp", 64'(mstatus_mpp_o), 64'd3);
    accept("mti");

    // Exception beats a pending MEI.
    csr_write(12'h300, 64'h8);
    exception_valid_i = 1'b1;
    exception_code_i  = 63'd5;
    exception_pc_i    = 64'h500;
    exception_tval_i  = 64'h77;
    mip_i             = 64'h800;
    mie_i             = 64'h800;
    step();
    clear_events();
    chk("prio_mcause", mcause_o, 64'd5);
    chk("prio_pc", redirect_pc_o, 64'h8000_0000);
    chk("prio_mepc", mepc_o, 64'h500);
    chk("prio_mpie", 64'(mstatus_mpie_o), 64'd1);
    accept("prio");

    // M-mode with MIE=0: pending MEI is not taken.
    mip_i = 64'h800;
    mie_i = 64'h800;
    step();
    clear_events();
    chk("masked_valid", 64'(redirect_valid_o), 64'd0);
    chk("masked_busy", 64'(busy_o), 64'd0);
    chk("masked_mcause", mcause_o, 64'd5);

    // MRET to U-mode.
    csr_write(12'h341, 64'h2000);
    csr_write(12'h300, 64'h80);
    mret_valid_i = 1'b1;
    step();
    clear_events();
    chk("mret_priv", 64'(privilege_o), 64'd0);
    chk("mret_mie", 64'(mstatus_mie_o), 64'd1);
    chk("mret_mpie", 64'(mstatus_mpie_o), 64'd1);
    chk("mret_mpp", 64'(mstatus_mpp_o), 64'd0);
    chk("mret_pc", redirect_pc_o, 64'h2000);
    chk("mret_valid", 64'(redirect_valid_o), 64'd1);
    accept("mret");

    // From U-mode: SSI beats STI, vectored to base + 4, odd commit PC aligned.
    mip_i       = 64'h22;
    mie_i       = 64'h22;
    commit_pc_i = 64'h4567;
    step();
    clear_events();
    chk("ssi_mcause", mcause_o, 64'h8000_0000_0000_0001);
    chk("ssi_pc", redirect_pc_o, 64'h8000_0004);
    chk("ssi_mepc", mepc_o, 64'h4566);
    chk("ssi_mpp", 64'(mstatus_mpp_o), 64'd0);
    chk("ssi_priv", 64'(privilege_o), 64'd3);
    chk("ssi_mpie", 64'(mstatus_mpie_o), 64'd1);
    accept("ssi");

    // mepc write clears bit 0.
    csr_write(12'h341, 64'h3001);
    chk("mepc_wr", mepc_o, 64'h3000);

    // Same write coincident with an exception is discarded; mode 10 behaves as direct.
    mtvec_i           = 64'h8000_0002;
    csr_we_i          = 1'b1;
    csr_addr_i        = 12'h341;
    csr_wdata_i       = 64'h3001;
    exception_valid_i = 1'b1;
    exception_code_i  = 63'd4;
    exception_pc_i    = 64'h600;
    exception_tval_i  = 64'h11;
    step();
    clear_events();
    chk("coll_mepc", mepc_o, 64'h600);
    chk("coll_mcause", mcause_o, 64'd4);
    chk("coll_mtval", mtval_o, 64'h11);
    chk("coll_pc", redirect_pc_o, 64'h8000_0000);

    // Reset mid-REDIRECT returns to BOOT.
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    chk("rst2_valid", 64'(redirect_valid_o), 64'd1);
    chk("rst2_pc", redirect_pc_o, 64'h400);
    chk("rst2_busy", 64'(busy_o), 64'd1);
    chk("rst2_mcause", mcause_o, 64'd0);
    chk("rst2_mepc", mepc_o, 64'd0);
    accept("rst2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
